// File: rtl/simple_rx_mcdma_stall_monitor.sv
// Stall/deadlock monitor for the AXI-Stream slave port of the Rx MCDMA.
// Flags a block when one channel's beat sits unaccepted for THRESHOLD cycles while the core is busy.
module simple_rx_mcdma_stall_monitor #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int THRESHOLD = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             s_axis_tvalid_i,
  input  logic             s_axis_tready_i,
  input  logic [CH_W-1:0]  s_axis_tdest_i,
  input  logic             inst_idle_i,
  input  logic             block_clear_i,
  output logic             block_o,
  output logic [CH_W-1:0]  block_ch_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [7:0]       block_count_o
);

  if (NUM_CH > (1 << CH_W)) begin : g_ch_w_check
    $error("CH_W too narrow for NUM_CH");
  end
  if (THRESHOLD < 2 || (64'(1) << CNT_W) <= 64'(THRESHOLD)) begin : g_cnt_w_check
    $error("THRESHOLD must be >= 2 and below 2**CNT_W");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WATCH   = 2'd1,
    S_BLOCKED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
  logic             block_q, block_d;
  logic [CH_W-1:0]  block_ch_q, block_ch_d;
  logic [7:0]       block_count_q, block_count_d;

  logic stall, progress;

  assign stall    = s_axis_tvalid_i & ~s_axis_tready_i & ~inst_idle_i;
  assign progress = s_axis_tvalid_i & s_axis_tready_i;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_ch_d      = cur_ch_q;
    block_ch_d    = block_ch_q;
    block_count_d = block_count_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (stall) begin
          state_d  = S_WATCH;
          cnt_d    = CNT_W'(1);
          cur_ch_d = s_axis_tdest_i;
        end
      end

      S_WATCH: begin
        if (stall && s_axis_tdest_i == cur_ch_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == THRESH_M1) begin
            state_d    = S_BLOCKED;
            block_ch_d = cur_ch_q;
            if (block_count_q != 8'hFF) block_count_d = block_count_q + 8'd1;
          end
        end else if (stall) begin
          // tdest moved while a beat was pending: restart the run on the new channel
          cnt_d    = CNT_W'(1);
          cur_ch_d = s_axis_tdest_i;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      S_BLOCKED: begin
        // tvalid low alone keeps the block: the core has not drained yet
        if (progress || inst_idle_i || block_clear_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (stall && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    block_d = (state_d == S_BLOCKED);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cur_ch_q      <= '0;
      block_q       <= 1'b0;
      block_ch_q    <= '0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_ch_q      <= cur_ch_d;
      block_q       <= block_d;
      block_ch_q    <= block_ch_d;
      block_count_q <= block_count_d;
    end
  end

  assign block_o        = block_q;
  assign block_ch_o     = block_ch_q;
  assign stall_cycles_o = cnt_q;
  assign block_count_o  = block_count_q;

endmodule

// File: doc/simple_rx_mcdma_stall_monitor.md
# simple_rx_mcdma_stall_monitor

Stall/deadlock monitor for the receive-side MCDMA (SimpleRxMCDMA), the counterpart of the transmit-side deadlock monitor. It watches the AXI-Stream slave port feeding the Rx MCDMA. It declares a block when a channel's beat has been presented but not accepted for a programmable number of consecutive cycles while the core is not idle. It reports the offending channel and keeps a saturating block-event count for the debug/status path.

## Interface
- NUM_CH, 4: number of DMA channels addressed by tdest
- CH_W, 2: tdest / channel index width (log2 NUM_CH)
- THRESHOLD, 1024: consecutive stall cycles required to declare a block (≥2)
- CNT_W, 16: stall counter width; must satisfy 2^CNT_W > THRESHOLD
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- s_axis_tvalid  in  1  monitored slave-port tvalid
- s_axis_tready  in  1  monitored slave-port tready (driven by Rx MCDMA)
- s_axis_tdest  in  CH_W  monitored channel select
- inst_idle  in  1  Rx MCDMA core idle indication
- block_clear  in  1  single-cycle software acknowledge; drops a reported block
- block  out  1  registered deadlock flag
- block_ch  out  CH_W  channel that was stalled when block was declared
- stall_cycles  out  CNT_W  current consecutive-stall count
- block_count  out  8  number of block events since reset, saturating at 255

## Operation
- Stall cycle: s_axis_tvalid=1 & s_axis_tready=0 & inst_idle=0.
- Progress cycle: s_axis_tvalid=1 & s_axis_tready=1.
- FSM with three states, one-hot or encoded:
  - IDLE: counter 0, block 0. On a stall cycle → WATCH, counter←1, cur_ch←s_axis_tdest.
  - WATCH: on a stall cycle with tdest==cur_ch, counter←counter+1. If counter+1==THRESHOLD → BLOCKED, block_ch←cur_ch, block_count+1. On a stall cycle with tdest≠cur_ch (protocol violation), counter←1 and cur_ch←new tdest; stay in WATCH. On a progress cycle, tvalid=0, or inst_idle=1 → IDLE, counter←0.
  - BLOCKED: block=1 and block_ch held. Counter keeps incrementing on stall cycles, saturating at 2^CNT_W−1. On a progress cycle, inst_idle=1, or block_clear=1 → IDLE, counter←0. tvalid=0 alone does not exit, because the core has not drained.
- block_clear outside BLOCKED is ignored.
- Simultaneous events in BLOCKED: block_clear together with a stall cycle → IDLE with counter 0 (clear wins). A new stall on the next cycle restarts at WATCH/1.
- Simultaneous in WATCH: a threshold-reaching stall cycle with inst_idle=1 cannot occur, because idle disqualifies the stall. Progress always wins over counting.
- block_count increments only on the WATCH→BLOCKED transition and saturates at 255 (no wrap).
- Reset mid-operation: any state → IDLE; all outputs return to reset values on the next edge and block_count clears.

## Timing
- Reset values: block=0, block_ch=0, stall_cycles=0, block_count=0, state=IDLE.
- All outputs are registered and change on the clock edge following the qualifying input cycle.
- block rises in the cycle after the THRESHOLD-th consecutive stall cycle, i.e. THRESHOLD cycles after stall onset as seen on block.
- block falls one cycle after the exiting progress/idle/clear cycle.
- stall_cycles equals the number of consecutive stall cycles sampled so far, with a one-cycle lag.
- No combinational path from inputs to outputs.

## Test plan
- THRESHOLD=8: tvalid=1, tready=0, tdest=2, inst_idle=0 held 8 cycles → block=1 starting cycle 9, block_ch=2, block_count=1, stall_cycles=8.
- Stall 7 cycles, then tready=1 for one cycle, then stall 7 more → block never asserts; stall_cycles returns to 0 after the handshake.
- Enter BLOCKED, then pulse block_clear together with continued stall → block=0 next cycle, stall_cycles=0; block reasserts 8 cycles later and block_count=2.
- Stall with tdest switching 1→3 at cycle 5 → counter restarts at 1; block asserts 8 stall cycles after the switch with block_ch=3.
- In BLOCKED, drop tvalid for 3 cycles → block stays 1. Then raise inst_idle → block=0 next cycle.
- Generate 260 block events → block_count saturates at 255. Assert reset mid-BLOCKED → all outputs 0 on the next cycle.
